// File: rtl/spi_agc_slave.sv
// SPI register slave for AGC control: mode/channel, two gains, read-only status.
// Define SPI_AGC_ERRCNT_EN to add a saturating frame-abort counter at address 6.
`timescale 1ns/1ps
module spi_agc_slave #(
  parameter logic [7:0]  GAIN_RST    = 8'h40,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       spi_clk,
  input  logic       reg_reset,
  input  logic       sclk,
  input  logic       spi_cs,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       miso_oe,
  output logic [1:0] control_mode,
  output logic       channel,
  output logic [7:0] gain_a,
  output logic [7:0] gain_b,
  input  logic [7:0] status_in,
  output logic       wr_strobe,
  output logic [2:0] wr_addr,
  output logic       busy
);

  localparam int unsigned SW = SYNC_STAGES;

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] sclk_sync_q, sclk_sync_d;
  logic [SW-1:0] cs_sync_q, cs_sync_d;
  logic [SW-1:0] mosi_sync_q, mosi_sync_d;
  logic [SW-1:0] vld_q, vld_d;
  logic          sclk_prev_q, sclk_prev_d;
  logic          armed_q, armed_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          rd_q, rd_d;
  logic [2:0]    addr_q, addr_d;
  logic [2:0]    reg0_q, reg0_d;
  logic [7:0]    gain_a_q, gain_a_d;
  logic [7:0]    gain_b_q, gain_b_d;
  logic          miso_q, miso_d;
  logic          oe_q, oe_d;
  logic          wr_strobe_q, wr_strobe_d;
  logic [2:0]    wr_addr_q, wr_addr_d;
  logic          busy_q, busy_d;
`ifdef SPI_AGC_ERRCNT_EN
  logic [7:0]    errcnt_q, errcnt_d;
  logic          abort_c;
`endif

  logic       sclk_s, cs_s, mosi_s, sclk_rise_c, sclk_fall_c;
  logic [2:0] cmd_addr_c;
  logic [7:0] wdata_c, rd_data_c;

  assign sclk_s      = sclk_sync_q[SW-1];
  assign cs_s        = cs_sync_q[SW-1];
  assign mosi_s      = mosi_sync_q[SW-1];
  assign sclk_rise_c = sclk_s & ~sclk_prev_q;
  assign sclk_fall_c = ~sclk_s & sclk_prev_q;
  assign cmd_addr_c  = {shreg_q[1:0], mosi_s};
  assign wdata_c     = {shreg_q[6:0], mosi_s};
`ifdef SPI_AGC_ERRCNT_EN
  assign abort_c     = ((state_q == CMD) || (state_q == DATA)) && cs_s;
`endif

  // Read-back mux, evaluated on the address completing at the 8th command bit
  always_comb begin
    case (cmd_addr_c)
      3'd0:    rd_data_c = {5'b0, reg0_q};
      3'd1:    rd_data_c = gain_a_q;
      3'd2:    rd_data_c = gain_b_q;
`ifdef SPI_AGC_ERRCNT_EN
      3'd6:    rd_data_c = errcnt_q;
`endif
      3'd7:    rd_data_c = status_in;
      default: rd_data_c = 8'h00;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    sclk_sync_d = {sclk_sync_q[SW-2:0], sclk};
    cs_sync_d   = {cs_sync_q[SW-2:0], spi_cs};
    mosi_sync_d = {mosi_sync_q[SW-2:0], spi_mosi};
    vld_d       = {vld_q[SW-2:0], 1'b1};
    sclk_prev_d = sclk_s;
    // Only a chip select seen high after the synchronizers refill can arm a frame
    armed_d     = armed_q | (vld_q[SW-1] & cs_s);
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    rd_d        = rd_q;
    addr_d      = addr_q;
    reg0_d      = reg0_q;
    gain_a_d    = gain_a_q;
    gain_b_d    = gain_b_q;
    miso_d      = miso_q;
    oe_d        = oe_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
`ifdef SPI_AGC_ERRCNT_EN
    errcnt_d    = errcnt_q;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (armed_q && !cs_s) state_d = CMD;
      end
      CMD: begin
        if (cs_s) begin
          state_d = IDLE;
        end else if (sclk_rise_c) begin
          shreg_d = wdata_c;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            rd_d    = shreg_q[6];
            addr_d  = cmd_addr_c;
            shreg_d = rd_data_c;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (cs_s) begin
          state_d = IDLE;
        end else if (sclk_rise_c) begin
          shreg_d = wdata_c;
          cnt_d   = cnt_q + 4'd1;
          if (rd_q) begin
            miso_d = shreg_q[7];
            oe_d   = 1'b1;
          end
          if (cnt_q == 4'd15) begin
            state_d = DONE;
            if (!rd_q) begin
              wr_addr_d = addr_q;
              case (addr_q)
                3'd0: begin reg0_d   = wdata_c[2:0]; wr_strobe_d = 1'b1; end
                3'd1: begin gain_a_d = wdata_c;      wr_strobe_d = 1'b1; end
                3'd2: begin gain_b_d = wdata_c;      wr_strobe_d = 1'b1; end
`ifdef SPI_AGC_ERRCNT_EN
                3'd6: begin errcnt_d = 8'h00;        wr_strobe_d = 1'b1; end
`endif
                default: wr_addr_d = wr_addr_q;
              endcase
            end
          end
        end
      end
      DONE: begin
        if (cs_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Bit 0 stays on the line until the master's falling edge after the 16th bit
    if ((state_d == IDLE) || ((state_q == DONE) && sclk_fall_c)) begin
      miso_d = 1'b0;
      oe_d   = 1'b0;
    end

`ifdef SPI_AGC_ERRCNT_EN
    if (abort_c && (errcnt_q != 8'hFF)) errcnt_d = errcnt_q + 8'd1;
`endif

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge spi_clk or posedge reg_reset) begin
    if (reg_reset) begin
      state_q     <= IDLE;
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      vld_q       <= '0;
      sclk_prev_q <= 1'b0;
      armed_q     <= 1'b0;
      cnt_q       <= 4'd0;
      shreg_q     <= 8'h00;
      rd_q        <= 1'b0;
      addr_q      <= 3'd0;
      reg0_q      <= 3'd0;
      gain_a_q    <= GAIN_RST;
      gain_b_q    <= GAIN_RST;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 3'd0;
      busy_q      <= 1'b0;
`ifdef SPI_AGC_ERRCNT_EN
      errcnt_q    <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      vld_q       <= vld_d;
      sclk_prev_q <= sclk_prev_d;
      armed_q     <= armed_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      reg0_q      <= reg0_d;
      gain_a_q    <= gain_a_d;
      gain_b_q    <= gain_b_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      busy_q      <= busy_d;
`ifdef SPI_AGC_ERRCNT_EN
      errcnt_q    <= errcnt_d;
`endif
    end
  end

  assign spi_miso     = miso_q;
  assign miso_oe      = oe_q;
  assign control_mode = reg0_q[1:0];
  assign channel      = reg0_q[2];
  assign gain_a       = gain_a_q;
  assign gain_b       = gain_b_q;
  assign wr_strobe    = wr_strobe_q;
  assign wr_addr      = wr_addr_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_spi_agc_slave.sv
// Bench for spi_agc_slave: randomized SPI frames, register model, queue-based scoreboard.
`timescale 1ns/1ps
module tb_spi_agc_slave;

  localparam int HALF = 8;

  logic       spi_clk = 1'b0;
  logic       reg_reset = 1'b1;
  logic       sclk = 1'b0;
  logic       spi_cs = 1'b1;
  logic       spi_mosi = 1'b0;
  logic [7:0] status_in = 8'h00;
  logic       spi_miso, miso_oe, channel, wr_strobe, busy;
  logic [1:0] control_mode;
  logic [7:0] gain_a, gain_b;
  logic [2:0] wr_addr;

  spi_agc_slave dut (
    .spi_clk(spi_clk), .reg_reset(reg_reset), .sclk(sclk), .spi_cs(spi_cs),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .miso_oe(miso_oe),
    .control_mode(control_mode), .channel(channel), .gain_a(gain_a), .gain_b(gain_b),
    .status_in(status_in), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .busy(busy)
  );

  always #5 spi_clk = ~spi_clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] ga;
    logic [7:0] gb;
    logic [2:0] r0;
  } wr_exp_t;

  wr_exp_t    wr_q[$];
  logic [7:0] rd_q[$];

  // Register model
  logic [2:0] m_reg0 = 3'd0;
  logic [7:0] m_ga = 8'h40;
  logic [7:0] m_gb = 8'h40;
`ifdef SPI_AGC_ERRCNT_EN
  logic [7:0] m_err = 8'h00;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [2:0] a, input logic [7:0] st);
    case (a)
      3'd0: return {5'b0, m_reg0};
      3'd1: return m_ga;
      3'd2: return m_gb;
`ifdef SPI_AGC_ERRCNT_EN
      3'd6: return m_err;
`endif
      3'd7: return st;
      default: return 8'h00;
    endcase
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge spi_clk);
  endtask

  task automatic shift_bits(input logic [15:0] word, input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi = word[15-i];
      cyc(HALF);
      sclk = 1'b1;
      cyc(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_reg0 = 3'd0;
    m_ga   = 8'h40;
    m_gb   = 8'h40;
`ifdef SPI_AGC_ERRCNT_EN
    m_err  = 8'h00;
`endif
  endtask

  // Predict the frame's effect, queue expected outputs, then drive it
  task automatic frame(input logic [7:0] cmd, input logic [7:0] data, input int nbits, input int extra);
    logic [2:0] a;
    logic       impl;
    wr_exp_t    e;
    a = cmd[2:0];
    if (nbits == 16) begin
      if (cmd[7]) begin
        rd_q.push_back(model_read(a, status_in));
      end else begin
        impl = 1'b1;
        case (a)
          3'd0: m_reg0 = data[2:0];
          3'd1: m_ga = data;
          3'd2: m_gb = data;
`ifdef SPI_AGC_ERRCNT_EN
          3'd6: m_err = 8'h00;
`endif
          default: impl = 1'b0;
        endcase
        if (impl) begin
          e.addr = a; e.ga = m_ga; e.gb = m_gb; e.r0 = m_reg0;
          wr_q.push_back(e);
        end
      end
    end else begin
`ifdef SPI_AGC_ERRCNT_EN
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
`endif
    end
    spi_cs = 1'b0;
    cyc(4);
    shift_bits({cmd, data}, nbits);
    cyc(HALF);
    if (nbits == 16) begin
      for (int k = 0; k < extra; k++) begin
        sclk = 1'b1; cyc(HALF);
        sclk = 1'b0; cyc(HALF);
      end
    end
    spi_cs = 1'b1;
    cyc(6);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_miso"}, 32'(spi_miso), 32'd0);
    chk({tag, "_oe"}, 32'(miso_oe), 32'd0);
    chk({tag, "_mode"}, 32'(control_mode), 32'd0);
    chk({tag, "_channel"}, 32'(channel), 32'd0);
    chk({tag, "_gain_a"}, 32'(gain_a), 32'h40);
    chk({tag, "_gain_b"}, 32'(gain_b), 32'h40);
    chk({tag, "_wr_strobe"}, 32'(wr_strobe), 32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Write monitor: every strobe must match the oldest expected write
  always @(negedge spi_clk) begin
    if (wr_strobe) begin
      if (wr_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL wr_strobe: unexpected pulse with wr_addr=%0d, expected no pulse", wr_addr);
      end else begin
        wr_exp_t e;
        e = wr_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_gain_a", 32'(gain_a), 32'(e.ga));
        chk("wr_gain_b", 32'(gain_b), 32'(e.gb));
        chk("wr_reg0", 32'({channel, control_mode}), 32'(e.r0));
      end
    end
  end

  // Read monitor: sample MISO on master falling edges while driven
  logic [7:0] cap = 8'h00;
  int         oe_n = 0;
  always @(negedge sclk or posedge spi_cs) begin
    if (spi_cs) begin
      if (oe_n != 0) begin
        if (rd_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rd_frame: unexpected read data %0h, expected none", cap);
        end else begin
          chk("rd_data", 32'(cap), 32'(rd_q.pop_front()));
          chk("rd_oe_bits", 32'(oe_n), 32'd8);
        end
      end
      oe_n = 0;
      cap  = 8'h00;
    end else if (miso_oe) begin
      cap  = {cap[6:0], spi_miso};
      oe_n = oe_n + 1;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cmd, data;
    int         nb;
    cyc(3);
    chk_reset_outputs("rst");
    reg_reset = 1'b0;
    cyc(6);

    frame(8'h01, 8'hA5, 16, 0);
    chk("a5_gain_a", 32'(gain_a), 32'(m_ga));
    chk("a5_gain_b", 32'(gain_b), 32'h40);
    frame(8'h02, 8'h3C, 16, 0);
    frame(8'h82, 8'h00, 16, 0);
    status_in = 8'h5A;
    frame(8'h87, 8'h00, 16, 0);
    frame(8'h07, 8'hFF, 16, 0);
    frame(8'h01, 8'h77, 12, 0);
    chk("abort_gain_a", 32'(gain_a), 32'(m_ga));
    frame(8'h86, 8'h00, 16, 0);

    // Reset in the middle of the data byte, chip select still low on release
    spi_cs = 1'b0;
    cyc(4);
    shift_bits({8'h00, 8'h07}, 12);
    reg_reset = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    model_reset();
    cyc(3);
    reg_reset = 1'b0;
    cyc(12);
    chk("no_resume_busy", 32'(busy), 32'd0);
    spi_cs = 1'b1;
    cyc(6);
    frame(8'h00, 8'h07, 16, 0);
    chk("post_rst_mode", 32'(control_mode), 32'd3);

    frame(8'h00, 8'h06, 16, 4);
    chk("extra_mode", 32'(control_mode), 32'd2);
    chk("extra_channel", 32'(channel), 32'd1);

    for (int n = 0; n < 40; n++) begin
      status_in = 8'($urandom);
      cmd  = 8'($urandom);
      data = 8'($urandom);
      nb   = 16;
      if (!cmd[7] && ($urandom_range(0, 3) == 0)) nb = $urandom_range(1, 15);
      frame(cmd, data, nb, $urandom_range(0, 3));
      if ((n % 8) == 7) frame(8'h86, 8'h00, 16, 0);
    end

    cyc(20);
    chk("wr_queue_drained", 32'(wr_q.size()), 32'd0);
    chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    chk("final_gain_a", 32'(gain_a), 32'(m_ga));
    chk("final_gain_b", 32'(gain_b), 32'(m_gb));
    chk("final_reg0", 32'({channel, control_mode}), 32'(m_reg0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
